fb_arbiter: RTL and testbench
=============================

Name: fb_arbiter

Overview:
- Shares the single-port framebuffer data memory (640x480 words) between the processor load/store port and the VGA scan-out path.
- Prefetches pixels sequentially into a small FIFO so the VGA side sees a steady pixel stream.
- Grants the processor every memory slot the video side does not urgently need.
- Sits between processor/DataMemory and the RGB output stage of the Frogger system.

Parameters:
- bus, 32, data/address width of CPU and memory ports
- FB_PIXELS, 307200, framebuffer size in words; video fetch address wraps here
- FIFO_DEPTH, 16, pixel prefetch FIFO entries (power of two, >=4)
- LOW_WATER, 4, below this occupancy the video path takes priority

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_re  in  1  processor read request
- cpu_we  in  1  processor write request
- cpu_addr  in  bus  processor word address
- cpu_wdata  in  bus  processor write data
- cpu_stall  out  1  request pending but not granted this cycle
- cpu_rdata  out  bus  read data
- cpu_rvalid  out  1  cpu_rdata valid (one cycle after read grant)
- mem_addr  out  bus  memory address
- mem_wdata  out  bus  memory write data
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_rdata  in  bus  memory read data, valid one cycle after mem_re
- frame_start  in  1  one-cycle pulse at start of vertical blank
- pix_pop  in  1  VGA consumes one pixel
- pix_data  out  24  FIFO head, low 24 bits of word {R,G,B}
- pix_valid  out  1  FIFO non-empty
- underflow_count  out  16  see Optional Feature

Behaviour:
- Reset (sync, active-high): all outputs 0, FIFO empty, fetch pointer 0, in-flight flag 0, state RUN.
- Memory timing: mem_* outputs are combinational from the current-cycle grant. Read data returns on mem_rdata the next cycle. At most one access per cycle.
- vid_ok = (fifo_count + inflight_vid) < FIFO_DEPTH and state == RUN.
- vid_urgent = vid_ok and fifo_count < LOW_WATER.
- CPU request = cpu_re | cpu_we. cpu_re and cpu_we both high: treated as write only.
- Grant priority: vid_urgent > CPU request > vid_ok > idle.
- CPU grant:
  - mem_addr=cpu_addr. Write: mem_we=1, mem_wdata=cpu_wdata. Read: mem_re=1.
  - cpu_stall=0. Read returns cpu_rdata=mem_rdata with cpu_rvalid=1 the next cycle.
- CPU request not granted: cpu_stall=1. The processor holds its request stable until cpu_stall falls.
- Video grant:
  - mem_re=1, mem_addr=fetch_ptr.
  - fetch_ptr increments; FB_PIXELS-1 wraps to 0.
  - inflight_vid=1; next cycle mem_rdata[23:0] is pushed to the FIFO.
- FIFO:
  - Push and pop in the same cycle: count unchanged.
  - pix_pop when empty is ignored, and counted under the optional feature.
  - Overflow cannot occur by construction. Verification asserts this.
- State machine:
  - RUN -> FLUSH on frame_start. That cycle: FIFO cleared, fetch_ptr=0, no video grant issued.
  - FLUSH lasts exactly one cycle. Any video data returning in that cycle is discarded. Then FLUSH -> RUN.
  - CPU is served normally in FLUSH. frame_start during FLUSH restarts FLUSH.
- pix_data/pix_valid reflect the FIFO head combinationally from registered storage.
- Reset mid-access: the returning read is dropped; no cpu_rvalid.

Optional Feature:
- Macro FB_UNDERFLOW_CNT_EN.
- Defined: underflow_count is a 16-bit saturating counter.
  - Increments each cycle pix_pop=1 while pix_valid=0.
  - Cleared by reset only; holds at 0xFFFF.
- Undefined: underflow_count tied to 0, no counter logic.

Test Plan:
- Reset then idle 40 cycles, mem_rdata=addr -> FIFO fills to 16, pix_data=0,1,2,... on pops, cpu_stall=0.
- FIFO at 10, cpu_we addr 0x100 data 0xABCD -> mem_we same cycle, addr 0x100, cpu_stall=0.
- FIFO at 2 with cpu_re pending -> video granted, cpu_stall=1 until FIFO reaches 4, then CPU read, cpu_rvalid next cycle.
- fetch_ptr=307199 -> next video address 0.
- frame_start while video read in flight -> returned word discarded, FIFO empty, next video address 0 after one cycle.
- FB_UNDERFLOW_CNT_EN defined: 5 pops on empty FIFO -> underflow_count=5. Undefined -> underflow_count=0.

Source files
------------

// File: rtl/fb_arbiter.sv
// Framebuffer memory arbiter: shares one single-port memory between the CPU and a
// prefetching VGA pixel FIFO. Optional saturating underflow counter: FB_UNDERFLOW_CNT_EN.
module fb_arbiter #(
    parameter int unsigned bus        = 32,
    parameter int unsigned FB_PIXELS  = 307200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LOW_WATER  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cpu_re,
    input  logic            cpu_we,
    input  logic [bus-1:0]  cpu_addr,
    input  logic [bus-1:0]  cpu_wdata,
    output logic            cpu_stall,
    output logic [bus-1:0]  cpu_rdata,
    output logic            cpu_rvalid,
    output logic [bus-1:0]  mem_addr,
    output logic [bus-1:0]  mem_wdata,
    output logic            mem_re,
    output logic            mem_we,
    input  logic [bus-1:0]  mem_rdata,
    input  logic            frame_start,
    input  logic            pix_pop,
    output logic [23:0]     pix_data,
    output logic            pix_valid,
    output logic [15:0]     underflow_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam int unsigned FP_W  = $clog2(FB_PIXELS);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [23:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [FP_W-1:0]  fetch_ptr;
    logic             inflight_vid;
    logic             inflight_cpu;

    logic             flush;
    logic             push;
    logic             pop;
    logic [OCC_W-1:0] occupancy;
    logic             vid_ok;
    logic             vid_urgent;
    logic             cpu_req;
    logic             grant_vid;
    logic             grant_cpu;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: FLUSH is a single cycle unless frame_start re-arms it
    always_comb begin
        state_next = RUN;
        if (frame_start) begin
            state_next = FLUSH;
        end
    end

    // Grant decision and memory strobes for the current cycle
    always_comb begin
        occupancy  = {1'b0, fifo_count} + OCC_W'(inflight_vid);
        vid_ok     = (state == RUN) && !frame_start && (occupancy < OCC_W'(FIFO_DEPTH));
        vid_urgent = vid_ok && (fifo_count < CNT_W'(LOW_WATER));
        cpu_req    = cpu_re | cpu_we;
        grant_vid  = 1'b0;
        grant_cpu  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        cpu_stall  = 1'b0;
        if (!reset) begin
            if (vid_urgent) begin
                grant_vid = 1'b1;
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end else if (vid_ok) begin
                grant_vid = 1'b1;
            end
            cpu_stall = cpu_req && !grant_cpu;
        end
        if (grant_cpu) begin
            mem_addr = cpu_addr;
            if (cpu_we) begin
                mem_we    = 1'b1;
                mem_wdata = cpu_wdata;
            end else begin
                mem_re = 1'b1;
            end
        end else if (grant_vid) begin
            mem_addr = bus'(fetch_ptr);
            mem_re   = 1'b1;
        end
    end

    assign flush      = frame_start || (state == FLUSH);
    assign push       = inflight_vid && !flush && !reset;
    assign pop        = pix_pop && (fifo_count != '0) && !flush;
    assign cpu_rvalid = inflight_cpu && !reset;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign pix_valid  = (fifo_count != '0);
    assign pix_data   = pix_valid ? fifo_mem[rd_ptr] : 24'h0;

    // FIFO storage; contents are only meaningful below fifo_count, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata[23:0];
        end
    end

    // Fetch pointer, in-flight tracking and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_count   <= '0;
            fetch_ptr    <= '0;
            inflight_vid <= 1'b0;
            inflight_cpu <= 1'b0;
        end else begin
            inflight_vid <= grant_vid;
            inflight_cpu <= grant_cpu && !cpu_we;
            if (flush) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fifo_count <= '0;
                fetch_ptr  <= '0;
            end else begin
                if (grant_vid) begin
                    if (fetch_ptr == FP_W'(FB_PIXELS - 1)) begin
                        fetch_ptr <= '0;
                    end else begin
                        fetch_ptr <= fetch_ptr + FP_W'(1);
                    end
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                    2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                    default: fifo_count <= fifo_count;
                endcase
            end
        end
    end

`ifdef FB_UNDERFLOW_CNT_EN
    logic [15:0] uf_cnt;

    // Saturating count of pops attempted against an empty FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            uf_cnt <= '0;
        end else if (pix_pop && !pix_valid && (uf_cnt != 16'hFFFF)) begin
            uf_cnt <= uf_cnt + 16'd1;
        end
    end

    assign underflow_count = uf_cnt;
`else
    assign underflow_count = '0;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: vector table for CPU/video sharing plus hand
// sequences for priority, frame flush, fetch wrap and underflow counting.
module tb_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_re, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_re, mem_we;
    logic        frame_start, pix_pop;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic [15:0] underflow_count;

    logic        cpu_stall2, cpu_rvalid2, mem_re2, mem_we2, pix_valid2;
    logic [31:0] cpu_rdata2, mem_addr2, mem_wdata2, mem_rdata2;
    logic [23:0] pix_data2;
    logic [15:0] underflow_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory model: every read returns its own address one cycle later
    always @(posedge clk) begin
        mem_rdata  <= mem_addr;
        mem_rdata2 <= mem_addr2;
    end

    fb_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .frame_start(frame_start), .pix_pop(pix_pop),
        .pix_data(pix_data), .pix_valid(pix_valid), .underflow_count(underflow_count)
    );

    // Small framebuffer instance to reach the fetch-address wrap quickly
    fb_arbiter #(.FB_PIXELS(20)) dut2 (
        .clk(clk), .reset(reset),
        .cpu_re(1'b0), .cpu_we(1'b0), .cpu_addr(32'h0), .cpu_wdata(32'h0),
        .cpu_stall(cpu_stall2), .cpu_rdata(cpu_rdata2), .cpu_rvalid(cpu_rvalid2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_re(mem_re2), .mem_we(mem_we2),
        .mem_rdata(mem_rdata2), .frame_start(1'b0), .pix_pop(1'b1),
        .pix_data(pix_data2), .pix_valid(pix_valid2), .underflow_count(underflow_count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // FIFO must never hold more than its depth
    always @(negedge clk) begin
        if (!reset && (dut.fifo_count > 5'd16)) begin
            errors++;
            $display("FAIL fifo_overflow: count %0d exceeds 16", dut.fifo_count);
        end
    end

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pop;
        logic        e_re;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_stall;
        logic        e_rvalid;
        logic [31:0] e_rdata;
        logic [23:0] e_pix;
    } vec_t;

    vec_t vecs [8];
    int   exp_uf;

    initial begin
        // Starts from a full FIFO holding 0..15, fetch pointer at 16
        vecs[0] = '{1'b1, 1'b0, 32'h40,  32'h0,    1'b1, 1'b1, 1'b0, 32'h40,  32'h0,    1'b0, 1'b0, 32'h0,  24'd0};
        vecs[1] = '{1'b1, 1'b0, 32'h41,  32'h0,    1'b1, 1'b1, 1'b0, 32'h41,  32'h0,    1'b0, 1'b1, 32'h40, 24'd1};
        vecs[2] = '{1'b1, 1'b0, 32'h42,  32'h0,    1'b1, 1'b1, 1'b0, 32'h42,  32'h0,    1'b0, 1'b1, 32'h41, 24'd2};
        vecs[3] = '{1'b1, 1'b1, 32'h43,  32'h55,   1'b1, 1'b0, 1'b1, 32'h43,  32'h55,   1'b0, 1'b1, 32'h42, 24'd3};
        vecs[4] = '{1'b1, 1'b0, 32'h44,  32'h0,    1'b1, 1'b1, 1'b0, 32'h44,  32'h0,    1'b0, 1'b0, 32'h0,  24'd4};
        vecs[5] = '{1'b1, 1'b0, 32'h45,  32'h0,    1'b1, 1'b1, 1'b0, 32'h45,  32'h0,    1'b0, 1'b1, 32'h44, 24'd5};
        vecs[6] = '{1'b0, 1'b1, 32'h100, 32'hABCD, 1'b0, 1'b0, 1'b1, 32'h100, 32'hABCD, 1'b0, 1'b1, 32'h45, 24'd6};
        vecs[7] = '{1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 1'b1, 1'b0, 32'd16,  32'h0,    1'b0, 1'b0, 32'h0,  24'd6};

`ifdef FB_UNDERFLOW_CNT_EN
        exp_uf = 5;
`else
        exp_uf = 0;
`endif

        reset = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        frame_start = 1'b0; pix_pop = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_mem_re", 32'(mem_re), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_stall", 32'(cpu_stall), 32'h0);
        check("rst_rvalid", 32'(cpu_rvalid), 32'h0);
        check("rst_pix_valid", 32'(pix_valid), 32'h0);
        check("rst_underflow", 32'(underflow_count), 32'h0);

        // Idle fill; meanwhile the small instance must wrap 19 -> 0
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i < 25) begin
                check("wrap_re", 32'(mem_re2), 32'h1);
                check("wrap_addr", mem_addr2, 32'(i % 20));
            end
            next_cycle();
        end
        @(negedge clk);
        check("fill_valid", 32'(pix_valid), 32'h1);
        check("fill_head", 32'(pix_data), 32'h0);
        check("fill_idle_re", 32'(mem_re), 32'h0);
        check("fill_stall", 32'(cpu_stall), 32'h0);

        for (int v = 0; v < 8; v++) begin
            next_cycle();
            cpu_re = vecs[v].re; cpu_we = vecs[v].we;
            cpu_addr = vecs[v].addr; cpu_wdata = vecs[v].wdata; pix_pop = vecs[v].pop;
            @(negedge clk);
            check($sformatf("v%0d_mem_re", v), 32'(mem_re), 32'(vecs[v].e_re));
            check($sformatf("v%0d_mem_we", v), 32'(mem_we), 32'(vecs[v].e_we));
            check($sformatf("v%0d_mem_addr", v), mem_addr, vecs[v].e_addr);
            check($sformatf("v%0d_mem_wdata", v), mem_wdata, vecs[v].e_wdata);
            check($sformatf("v%0d_stall", v), 32'(cpu_stall), 32'(vecs[v].e_stall));
            check($sformatf("v%0d_rvalid", v), 32'(cpu_rvalid), 32'(vecs[v].e_rvalid));
            check($sformatf("v%0d_rdata", v), cpu_rdata, vecs[v].e_rdata);
            check($sformatf("v%0d_pix", v), 32'(pix_data), 32'(vecs[v].e_pix));
        end

        // Low FIFO: video wins over a pending CPU read until four words are buffered
        next_cycle();
        reset = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; pix_pop = 1'b0;
        next_cycle();
        reset = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h200;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("urg%0d_stall", c), 32'(cpu_stall), 32'h1);
            check($sformatf("urg%0d_re", c), 32'(mem_re), 32'h1);
            check($sformatf("urg%0d_addr", c), mem_addr, 32'(c));
            next_cycle();
        end
        @(negedge clk);
        check("urg_cpu_stall", 32'(cpu_stall), 32'h0);
        check("urg_cpu_re", 32'(mem_re), 32'h1);
        check("urg_cpu_addr", mem_addr, 32'h200);
        next_cycle();
        cpu_re = 1'b0;
        @(negedge clk);
        check("urg_rvalid", 32'(cpu_rvalid), 32'h1);
        check("urg_rdata", cpu_rdata, 32'h200);
        check("urg_vid_addr", mem_addr, 32'd5);

        // frame_start while word 5 is returning
        next_cycle();
        frame_start = 1'b1;
        @(negedge clk);
        check("fs_no_grant", 32'(mem_re), 32'h0);
        next_cycle();
        frame_start = 1'b0; cpu_we = 1'b1; cpu_addr = 32'h300; cpu_wdata = 32'h7;
        @(negedge clk);
        check("flush_cpu_we", 32'(mem_we), 32'h1);
        check("flush_cpu_addr", mem_addr, 32'h300);
        check("flush_stall", 32'(cpu_stall), 32'h0);
        check("flush_empty", 32'(pix_valid), 32'h0);
        next_cycle();
        cpu_we = 1'b0;
        @(negedge clk);
        check("post_flush_re", 32'(mem_re), 32'h1);
        check("post_flush_addr", mem_addr, 32'h0);
        check("post_flush_empty", 32'(pix_valid), 32'h0);
        next_cycle();
        @(negedge clk);
        check("post_flush_addr1", mem_addr, 32'h1);
        next_cycle();
        @(negedge clk);
        check("post_flush_valid", 32'(pix_valid), 32'h1);
        check("post_flush_head", 32'(pix_data), 32'h0);

        // Five pops against an empty FIFO held in flush
        next_cycle();
        frame_start = 1'b1;
        for (int p = 0; p < 5; p++) begin
            next_cycle();
            pix_pop = 1'b1;
            @(negedge clk);
            check($sformatf("uf%0d_empty", p), 32'(pix_valid), 32'h0);
        end
        next_cycle();
        frame_start = 1'b0; pix_pop = 1'b0;
        @(negedge clk);
        check("underflow_count", 32'(underflow_count), 32'(exp_uf));

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
